// File: rtl/seq_fixed_mult_if.sv
// Operand/result handshake bundle for the sequential sign-magnitude multiplier.
// The producer side uses master, and the multiplier uses slave.
interface seq_fixed_mult_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_ovf
    );
endinterface

// File: rtl/seq_fixed_mult.sv
// Shift-add sign-magnitude fixed-point multiplier that handles one magnitude bit per cycle.
// It saturates the result, can round the result, and never produces a negative zero.
module seq_fixed_mult #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ROUND = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    seq_fixed_mult_if.slave  bus
);
    localparam int M   = WIDTH - 1;
    localparam int AW  = 2 * M;
    localparam int PW  = AW + 1;
    localparam int CW  = $clog2(M + 1);
    localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic [PW-1:0] RND = (ROUND != 0 && FRAC > 0) ? (PW'(1) << RSH) : '0;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nx;
    logic             sign_q, sign_nx;
    logic [AW-1:0]    a_sh, a_sh_nx;
    logic [AW-1:0]    acc, acc_nx;
    logic [M-1:0]     b_sh, b_sh_nx;
    logic [CW-1:0]    count, count_nx;
    logic [WIDTH-1:0] res_q, res_nx;
    logic             ovf_q, ovf_nx;

    logic [PW-1:0]    p_sum;
    logic [PW-1:0]    mag;
    logic [M-1:0]     mag_fin;
    logic             sat;

    // The finished accumulator is rounded, shifted down to the output Q format, and clamped.
    always_comb begin
        p_sum   = {1'b0, acc} + RND;
        mag     = p_sum >> FRAC;
        sat     = |mag[PW-1:M];
        mag_fin = sat ? {M{1'b1}} : mag[M-1:0];
    end

    always_comb begin
        state_nx = state;
        sign_nx  = sign_q;
        a_sh_nx  = a_sh;
        acc_nx   = acc;
        b_sh_nx  = b_sh;
        count_nx = count;
        res_nx   = res_q;
        ovf_nx   = ovf_q;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_nx  = bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1];
                    a_sh_nx  = {{M{1'b0}}, bus.in_a[M-1:0]};
                    b_sh_nx  = bus.in_b[M-1:0];
                    acc_nx   = '0;
                    count_nx = '0;
                    state_nx = RUN;
                end
            end
            RUN: begin
                // After the last iteration, one extra cycle registers the result.
                if (count == CW'(M)) begin
                    res_nx   = {(mag_fin != '0) & sign_q, mag_fin};
                    ovf_nx   = sat;
                    state_nx = DONE;
                end else begin
                    if (b_sh[0]) begin
                        acc_nx = acc + a_sh;
                    end
                    a_sh_nx  = a_sh << 1;
                    b_sh_nx  = b_sh >> 1;
                    count_nx = count + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sign_q <= 1'b0;
            a_sh <= '0;
            acc <= '0;
            b_sh <= '0;
            count <= '0;
            res_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nx;
            sign_q <= sign_nx;
            a_sh <= a_sh_nx;
            acc <= acc_nx;
            b_sh <= b_sh_nx;
            count <= count_nx;
            res_q <= res_nx;
            ovf_q <= ovf_nx;
        end
    end

    assign bus.in_ready   = (state == IDLE);
    assign bus.out_valid  = (state == DONE);
    assign bus.out_result = res_q;
    assign bus.out_ovf    = ovf_q;
endmodule

// File: tb/tb_seq_fixed_mult.sv
// Directed and random bench for seq_fixed_mult using three parameter sets.
// Instance 0 is W16/F8 truncate, instance 1 is W16/F8 round, and instance 2 is W8/F0.
module tb_seq_fixed_mult;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_fixed_mult_if #(.WIDTH(16)) if16  ();
    seq_fixed_mult_if #(.WIDTH(16)) if16r ();
    seq_fixed_mult_if #(.WIDTH(8))  if8   ();

    seq_fixed_mult #(.WIDTH(16), .FRAC(8), .ROUND(0)) u16  (.clk(clk), .rst_n(rst_n), .bus(if16));
    seq_fixed_mult #(.WIDTH(16), .FRAC(8), .ROUND(1)) u16r (.clk(clk), .rst_n(rst_n), .bus(if16r));
    seq_fixed_mult #(.WIDTH(8),  .FRAC(0), .ROUND(0)) u8   (.clk(clk), .rst_n(rst_n), .bus(if8));

    function automatic logic get_valid(input int sel);
        case (sel)
            0: return if16.out_valid;
            1: return if16r.out_valid;
            default: return if8.out_valid;
        endcase
    endfunction

    function automatic logic get_ready(input int sel);
        case (sel)
            0: return if16.in_ready;
            1: return if16r.in_ready;
            default: return if8.in_ready;
        endcase
    endfunction

    function automatic logic [31:0] get_res(input int sel);
        case (sel)
            0: return 32'(if16.out_result);
            1: return 32'(if16r.out_result);
            default: return 32'(if8.out_result);
        endcase
    endfunction

    function automatic logic get_ovf(input int sel);
        case (sel)
            0: return if16.out_ovf;
            1: return if16r.out_ovf;
            default: return if8.out_ovf;
        endcase
    endfunction

    task automatic drive_in(input int sel, input logic v, input logic [31:0] a, input logic [31:0] b);
        case (sel)
            0: begin if16.in_valid = v; if16.in_a = a[15:0]; if16.in_b = b[15:0]; end
            1: begin if16r.in_valid = v; if16r.in_a = a[15:0]; if16r.in_b = b[15:0]; end
            default: begin if8.in_valid = v; if8.in_a = a[7:0]; if8.in_b = b[7:0]; end
        endcase
    endtask

    task automatic set_ready(input int sel, input logic r);
        case (sel)
            0: if16.out_ready = r;
            1: if16r.out_ready = r;
            default: if8.out_ready = r;
        endcase
    endtask

    // This is an arithmetic reference that uses a full-width multiply, not the shift-add structure.
    function automatic void ref_model(input int w, input int f, input int r,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] res, output logic ovf);
        int m;
        logic [63:0] maxm, ma, mb, p, mag;
        logic s;
        m = w - 1;
        maxm = (64'd1 << m) - 64'd1;
        ma = 64'(a) & maxm;
        mb = 64'(b) & maxm;
        p = ma * mb;
        if (r != 0 && f > 0) p = p + (64'd1 << (f - 1));
        mag = p >> f;
        ovf = (mag > maxm);
        if (ovf) mag = maxm;
        s = a[m] ^ b[m];
        if (mag == 64'd0) s = 1'b0;
        res = 32'(mag) | (32'(s) << m);
    endfunction

    // Accept one operand pair, then wait (with a time limit) for the result and consume it.
    // The out_ready signal must already be high.
    task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ovf, output int lat);
        drive_in(sel, 1'b1, a, b);
        @(posedge clk); #1;
        drive_in(sel, 1'b0, 32'd0, 32'd0);
        lat = 0;
        while (!get_valid(sel) && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        res = get_res(sel);
        ovf = get_ovf(sel);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if (get_ready(s) !== 1'b1 || get_valid(s) !== 1'b0 || get_res(s) !== 32'd0 || get_ovf(s) !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset[%0d] ready=%b valid=%b res=%h ovf=%b expected 1 0 0 0",
                         s, get_ready(s), get_valid(s), get_res(s), get_ovf(s));
            end
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [31:0] va [9] = '{32'h0180, 32'h8180, 32'h8180, 32'h7F00, 32'hFF00, 32'h7FFF, 32'h0001, 32'h8001, 32'h0100};
        logic [31:0] vb [9] = '{32'h0200, 32'h0200, 32'h8200, 32'h0200, 32'h0200, 32'h0100, 32'h0080, 32'h0001, 32'h0100};
        logic [31:0] ve [9] = '{32'h0300, 32'h8300, 32'h0300, 32'h7FFF, 32'hFFFF, 32'h7FFF, 32'h0000, 32'h0000, 32'h0100};
        logic        vo [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] res;
        logic ovf;
        int lat;
        for (int i = 0; i < 9; i++) begin
            run_op(0, va[i], vb[i], res, ovf, lat);
            checks++;
            if (res !== ve[i] || ovf !== vo[i]) begin
                errors++;
                $display("[TB] FAIL basic[%0d] res=%h ovf=%b expected %h ovf=%b", i, res, ovf, ve[i], vo[i]);
            end
            checks++;
            if (lat !== 16) begin
                errors++;
                $display("[TB] FAIL basic_latency[%0d] got %0d expected 16", i, lat);
            end
        end
    endtask

    task automatic test_rounding();
        logic [31:0] va [3] = '{32'h0001, 32'h8001, 32'h8001};
        logic [31:0] vb [3] = '{32'h0080, 32'h0080, 32'h0001};
        logic [31:0] ve [3] = '{32'h0001, 32'h8001, 32'h0000};
        logic [31:0] res;
        logic ovf;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_op(1, va[i], vb[i], res, ovf, lat);
            checks++;
            if (res !== ve[i] || ovf !== 1'b0 || lat !== 16) begin
                errors++;
                $display("[TB] FAIL round[%0d] res=%h ovf=%b lat=%0d expected %h ovf=0 lat=16",
                         i, res, ovf, lat, ve[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int lat;
        int extra;
        set_ready(0, 1'b0);
        drive_in(0, 1'b1, 32'h0180, 32'h0200);
        @(posedge clk); #1;
        drive_in(0, 1'b0, 32'd0, 32'd0);
        lat = 0;
        while (!get_valid(0) && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        held = get_res(0);
        checks++;
        if (held !== 32'h0300 || lat !== 16) begin
            errors++;
            $display("[TB] FAIL bp_first res=%h lat=%0d expected 0300 lat=16", held, lat);
        end
        for (int i = 0; i < 5; i++) begin
            drive_in(0, 1'b1, 32'h0101, 32'h0101);
            @(posedge clk); #1;
            checks++;
            if (get_valid(0) !== 1'b1 || get_ready(0) !== 1'b0 || get_res(0) !== 32'h0300) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d] valid=%b ready=%b res=%h expected 1 0 0300",
                         i, get_valid(0), get_ready(0), get_res(0));
            end
        end
        drive_in(0, 1'b0, 32'd0, 32'd0);
        set_ready(0, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (get_valid(0) !== 1'b0 || get_ready(0) !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release valid=%b ready=%b expected 0 1", get_valid(0), get_ready(0));
        end
        extra = 0;
        for (int i = 0; i < 24; i++) begin
            if (get_valid(0)) extra++;
            @(posedge clk); #1;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("[TB] FAIL bp_extra_valid cycles=%0d expected 0", extra);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res;
        logic ovf;
        int lat;
        int seen;
        drive_in(0, 1'b1, 32'h0180, 32'h0200);
        @(posedge clk); #1;
        drive_in(0, 1'b0, 32'd0, 32'd0);
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #1;
        checks++;
        if (get_ready(0) !== 1'b1 || get_valid(0) !== 1'b0 || get_res(0) !== 32'd0 || get_ovf(0) !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_clear ready=%b valid=%b res=%h ovf=%b expected 1 0 0 0",
                     get_ready(0), get_valid(0), get_res(0), get_ovf(0));
        end
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1;
            if (get_valid(0)) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("[TB] FAIL midreset_no_valid cycles=%0d expected 0", seen);
        end
        run_op(0, 32'h0100, 32'h0100, res, ovf, lat);
        checks++;
        if (res !== 32'h0100 || ovf !== 1'b0 || lat !== 16) begin
            errors++;
            $display("[TB] FAIL midreset_fresh res=%h ovf=%b lat=%0d expected 0100 0 16", res, ovf, lat);
        end
    endtask

    task automatic test_param_sweep();
        logic [31:0] res;
        logic ovf;
        int lat;
        run_op(2, 32'h05, 32'h07, res, ovf, lat);
        checks++;
        if (res !== 32'h23 || ovf !== 1'b0 || lat !== 8) begin
            errors++;
            $display("[TB] FAIL w8_basic res=%h ovf=%b lat=%0d expected 23 0 8", res, ovf, lat);
        end
        run_op(2, 32'h0C, 32'h8B, res, ovf, lat);
        checks++;
        if (res !== 32'hFF || ovf !== 1'b1 || lat !== 8) begin
            errors++;
            $display("[TB] FAIL w8_sat res=%h ovf=%b lat=%0d expected ff 1 8", res, ovf, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, res, exp_res, wmask;
        logic ovf, exp_ovf;
        int lat, sel, w, f, r, m;
        for (int i = 0; i < 1000; i++) begin
            sel = $urandom_range(0, 2);
            w = (sel == 2) ? 8 : 16;
            f = (sel == 2) ? 0 : 8;
            r = (sel == 1) ? 1 : 0;
            m = w - 1;
            wmask = (32'd1 << w) - 32'd1;
            a = $urandom & wmask;
            b = $urandom & wmask;
            if ($urandom_range(0, 1) == 1) begin
                a = a & ((32'd1 << m) | ((32'd1 << (m / 2 + 1)) - 32'd1));
                b = b & ((32'd1 << m) | ((32'd1 << (m / 2 + 1)) - 32'd1));
            end
            ref_model(w, f, r, a, b, exp_res, exp_ovf);
            run_op(sel, a, b, res, ovf, lat);
            checks++;
            if (res !== exp_res || ovf !== exp_ovf || lat !== m + 1) begin
                errors++;
                $display("[TB] FAIL random[%0d] sel=%0d a=%h b=%h res=%h ovf=%b lat=%0d expected %h %b %0d",
                         i, sel, a, b, res, ovf, lat, exp_res, exp_ovf, m + 1);
            end
        end
    endtask

    initial begin
        if16.in_valid = 1'b0; if16.in_a = '0; if16.in_b = '0; if16.out_ready = 1'b1;
        if16r.in_valid = 1'b0; if16r.in_a = '0; if16r.in_b = '0; if16r.out_ready = 1'b1;
        if8.in_valid = 1'b0; if8.in_a = '0; if8.in_b = '0; if8.out_ready = 1'b1;
    end

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_backpressure();
        test_reset_mid_op();
        test_param_sweep();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
